// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, per-button debounce FSM with
// stability counter, clean level output, press/release pulses and optional
// auto-repeat press pulses while a button is held.
module button_debounce #(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_BTN-1:0] btn_ni,
    input  logic             repeat_en_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o
);

    localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RcntW = $clog2(REPEAT_DELAY + 1);

    typedef logic [DcntW-1:0] dcnt_t;
    typedef logic [RcntW-1:0] rcnt_t;

    localparam dcnt_t DcntLast = dcnt_t'(DEBOUNCE_CYCLES - 1);
    localparam dcnt_t DcntSat  = dcnt_t'(DEBOUNCE_CYCLES);
    localparam rcnt_t RcntFire = rcnt_t'(REPEAT_DELAY - 1);
    localparam rcnt_t RcntSat  = rcnt_t'(REPEAT_DELAY);
    // After a repeat pulse, reloading here makes the next fire REPEAT_PERIOD cycles later.
    localparam rcnt_t RcntReload = rcnt_t'(REPEAT_DELAY - REPEAT_PERIOD);

    typedef enum logic [1:0] {
        StReleased,
        StPressChk,
        StHeld,
        StReleaseChk
    } state_e;

    // Sync flops hold the raw (active-low) value; reset to 1 means released.
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] pressed;

    // Two-stage synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_e state_q;
        dcnt_t  dcnt_q;
        rcnt_t  rcnt_q;
        rcnt_t  rcnt_step;
        logic   rep_fire;
        logic   press_q;
        logic   release_q;

        // Next repeat-counter value and repeat-fire flag while the button is held.
        always_comb begin
            rep_fire  = 1'b0;
            rcnt_step = rcnt_q;
            if (!repeat_en_i) begin
                rcnt_step = '0;
            end else if (rcnt_q == RcntFire) begin
                rep_fire  = 1'b1;
                rcnt_step = RcntReload;
            end else if (rcnt_q != RcntSat) begin
                rcnt_step = rcnt_q + rcnt_t'(1);
            end
        end

        // Debounce FSM with registered press/release pulses.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q   <= StReleased;
                dcnt_q    <= '0;
                rcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                unique case (state_q)
                    StReleased: begin
                        rcnt_q <= '0;
                        if (pressed[i]) begin
                            state_q <= StPressChk;
                            dcnt_q  <= dcnt_t'(1);
                        end
                    end
                    StPressChk: begin
                        if (!pressed[i]) begin
                            state_q <= StReleased;
                            dcnt_q  <= '0;
                        end else if (dcnt_q == DcntLast) begin
                            state_q <= StHeld;
                            dcnt_q  <= '0;
                            rcnt_q  <= '0;
                            press_q <= 1'b1;
                        end else if (dcnt_q != DcntSat) begin
                            dcnt_q <= dcnt_q + dcnt_t'(1);
                        end
                    end
                    StHeld: begin
                        rcnt_q  <= rcnt_step;
                        press_q <= rep_fire;
                        if (!pressed[i]) begin
                            state_q <= StReleaseChk;
                            dcnt_q  <= dcnt_t'(1);
                        end
                    end
                    StReleaseChk: begin
                        if (pressed[i]) begin
                            // Bounce back to held: no pulse, repeat timing carries on.
                            state_q <= StHeld;
                            dcnt_q  <= '0;
                            rcnt_q  <= rcnt_step;
                            press_q <= rep_fire;
                        end else if (dcnt_q == DcntLast) begin
                            state_q   <= StReleased;
                            dcnt_q    <= '0;
                            rcnt_q    <= '0;
                            release_q <= 1'b1;
                        end else begin
                            if (dcnt_q != DcntSat) begin
                                dcnt_q <= dcnt_q + dcnt_t'(1);
                            end
                            rcnt_q  <= rcnt_step;
                            press_q <= rep_fire;
                        end
                    end
                endcase
            end
        end

        assign btn_level_o[i]   = (state_q == StHeld) || (state_q == StReleaseChk);
        assign btn_press_o[i]   = press_q;
        assign btn_release_o[i] = release_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with short debounce/repeat timing.
module tb_button_debounce;

    localparam int unsigned NB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_n = 2'b11;
    logic          rep_en = 1'b0;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] release_p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Edge stamps of every observed pulse, per button.
    int pq0[$];
    int pq1[$];
    int rq0[$];
    int rq1[$];

    button_debounce #(
        .N_BTN          (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .btn_ni       (btn_n),
        .repeat_en_i  (rep_en),
        .btn_level_o  (level),
        .btn_press_o  (press),
        .btn_release_o(release_p)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (press[0])     pq0.push_back(cyc);
        if (press[1])     pq1.push_back(cyc);
        if (release_p[0]) rq0.push_back(cyc);
        if (release_p[1]) rq1.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        pq0.delete();
        pq1.delete();
        rq0.delete();
        rq1.delete();
    endtask

    task automatic test_reset();
        int bad;
        rst_n  = 1'b0;
        btn_n  = 2'b11;
        rep_en = 1'b0;
        step(3);
        rep_en = 1'b1;
        #2;
        checks++;
        if ({level, press, release_p} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs_en1: got %b want 000000", {level, press, release_p});
        end
        rep_en = 1'b0;
        step(2);
        checks++;
        if ({level, press, release_p} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs_en0: got %b want 000000", {level, press, release_p});
        end
        #3 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if ({level, press, release_p} !== 6'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d nonzero cycles want 0", bad);
        end
    endtask

    task automatic test_single_press();
        int e;
        clear_logs();
        rep_en   = 1'b0;
        e        = cyc + 1;
        btn_n[0] = 1'b0;
        step(5);
        checks++;
        if (level[0] !== 1'b0) begin
            errors++;
            $display("FAIL level_before_accept: got %b want 0", level[0]);
        end
        step(1);
        checks++;
        if (level[0] !== 1'b1 || press[0] !== 1'b1) begin
            errors++;
            $display("FAIL accept_edge: got level=%b press=%b want 1 1", level[0], press[0]);
        end
        step(15);
        checks++;
        if (pq0.size() != 1 || pq0[0] != e + 5) begin
            errors++;
            $display("FAIL single_press_time: got n=%0d first=%0d want n=1 at %0d",
                     pq0.size(), (pq0.size() > 0) ? pq0[0] : -1, e + 5);
        end
        checks++;
        if (pq1.size() != 0 || level[1] !== 1'b0) begin
            errors++;
            $display("FAIL bit1_silent: got n=%0d level=%b want 0 0", pq1.size(), level[1]);
        end
        e        = cyc + 1;
        btn_n[0] = 1'b1;
        step(12);
        checks++;
        if (rq0.size() != 1 || rq0[0] != e + 5 || level[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got n=%0d first=%0d level=%b want n=1 at %0d level 0",
                     rq0.size(), (rq0.size() > 0) ? rq0[0] : -1, level[0], e + 5);
        end
    endtask

    task automatic test_glitch();
        int   s;
        logic pat [0:6];
        clear_logs();
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        s = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            btn_n[0] = pat[i];
            step(1);
        end
        btn_n[0] = 1'b0;
        step(20);
        checks++;
        if (pq0.size() != 1 || pq0[0] != s + 12) begin
            errors++;
            $display("FAIL glitch_press: got n=%0d first=%0d want n=1 at %0d",
                     pq0.size(), (pq0.size() > 0) ? pq0[0] : -1, s + 12);
        end
        btn_n[0] = 1'b1;
        step(12);
    endtask

    task automatic test_repeat();
        int p;
        int exp_off [0:4];
        int bad;
        clear_logs();
        exp_off = '{0, 20, 28, 36, 44};
        rep_en   = 1'b1;
        p        = cyc + 6;
        btn_n[0] = 1'b0;
        step(50);
        btn_n[0] = 1'b1;
        step(30);
        checks++;
        if (pq0.size() != 5) begin
            errors++;
            $display("FAIL repeat_count: got %0d want 5", pq0.size());
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < pq0.size() && pq0[i] != p + exp_off[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL repeat_times: got %0d misplaced pulses want 0 (press at %0d)", bad, p);
        end
        checks++;
        if (rq0.size() != 1 || rq0[0] != p + 50) begin
            errors++;
            $display("FAIL repeat_release: got n=%0d first=%0d want n=1 at %0d",
                     rq0.size(), (rq0.size() > 0) ? rq0[0] : -1, p + 50);
        end
        rep_en = 1'b0;
    endtask

    task automatic test_both();
        int e;
        clear_logs();
        rep_en = 1'b0;
        e      = cyc + 1;
        btn_n  = 2'b00;
        step(35);
        btn_n[0] = 1'b1;
        step(4);
        btn_n[1] = 1'b1;
        step(15);
        checks++;
        if (pq0.size() != 1 || pq1.size() != 1 || pq0[0] != e + 5 || pq1[0] != e + 5) begin
            errors++;
            $display("FAIL both_press: got n0=%0d n1=%0d want one each at %0d",
                     pq0.size(), pq1.size(), e + 5);
        end
        checks++;
        if (rq0.size() != 1 || rq0[0] != e + 40) begin
            errors++;
            $display("FAIL stagger_rel0: got n=%0d first=%0d want n=1 at %0d",
                     rq0.size(), (rq0.size() > 0) ? rq0[0] : -1, e + 40);
        end
        checks++;
        if (rq1.size() != 1 || rq1[0] != e + 44) begin
            errors++;
            $display("FAIL stagger_rel1: got n=%0d first=%0d want n=1 at %0d",
                     rq1.size(), (rq1.size() > 0) ? rq1[0] : -1, e + 44);
        end
    endtask

    task automatic test_reset_mid_hold();
        int r;
        clear_logs();
        btn_n[0] = 1'b0;
        step(12);
        checks++;
        if (level[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_before_reset: got %b want 1", level[0]);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (level[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_level_drop: got %b want 0", level[0]);
        end
        step(2);
        #2 rst_n = 1'b1;
        r = cyc + 1;
        step(20);
        checks++;
        if (pq0.size() != 2 || pq0[1] != r + 5) begin
            errors++;
            $display("FAIL repress_after_reset: got n=%0d last=%0d want n=2 last at %0d",
                     pq0.size(), (pq0.size() > 0) ? pq0[pq0.size()-1] : -1, r + 5);
        end
        checks++;
        if (rq0.size() != 0) begin
            errors++;
            $display("FAIL no_release_on_reset: got %0d release pulses want 0", rq0.size());
        end
        btn_n[0] = 1'b1;
        step(12);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_repeat();
        test_both();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
